// File: rtl/game_sequencer.sv
// game_sequencer: game-level controller for the Frogger datapath.
// Sequences the core through IDLE/PLAY/DYING/CLEAR/OVER, owns score, lives,
// level and round timer, and selects the value shown on the hex displays.
// Optional feature macro: GAME_SEQ_HIGHSCORE_EN (high-score register and
// high-score display mode); without it high_score and hs_mode are tied to 0.
module game_sequencer #(
  parameter int unsigned LIVES          = 3,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned ROUND_SECONDS  = 30,
  parameter int unsigned DEATH_FRAMES   = 60,
  parameter int unsigned PTS_STEP       = 10,
  parameter int unsigned PTS_HOME       = 50
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  keycode,
  input  logic        frame_tick,
  input  logic        frog_hop,
  input  logic        frog_hit,
  input  logic        frog_home,
  output logic        core_reset,
  output logic        freeze,
  output logic [2:0]  state,
  output logic [1:0]  lives,
  output logic [3:0]  level,
  output logic [5:0]  timer,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic [15:0] score_disp,
  output logic        hs_mode
);

  localparam logic [7:0]  KEY_SPACE = 8'h2C;
  localparam logic [7:0]  KEY_ESC   = 8'h29;
  localparam logic [7:0]  KEY_HS    = 8'h0B;
  localparam logic [16:0] SCORE_CAP = 17'd9999;

  // One frame counter serves both the seconds prescaler (PLAY) and the
  // death delay (DYING), so it is sized for the larger of the two.
  localparam int unsigned FCNT_MAX = (FRAMES_PER_SEC > DEATH_FRAMES) ? FRAMES_PER_SEC : DEATH_FRAMES;
  localparam int unsigned CW       = (FCNT_MAX < 2) ? 1 : $clog2(FCNT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DYING = 3'd2,
    ST_CLEAR = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_core_reset;
  logic          r_freeze;
  logic [1:0]    r_lives;
  logic [3:0]    r_level;
  logic [5:0]    r_timer;
  logic [15:0]   r_score;
  logic [CW-1:0] r_fcnt;

  logic w_start;
  logic w_esc;
  logic w_sec_wrap;
  logic w_death_done;
  logic w_timeout;

  assign w_start      = (keycode == KEY_SPACE);
  assign w_esc        = (keycode == KEY_ESC);
  assign w_sec_wrap   = (r_fcnt == CW'(FRAMES_PER_SEC - 1));
  assign w_death_done = (r_fcnt == CW'(DEATH_FRAMES - 1));
  assign w_timeout    = (r_timer == '0);

  // 17-bit sum clamped to the four-digit display limit.
  function automatic logic [15:0] f_sat_add(input logic [15:0] a, input logic [16:0] b);
    logic [16:0] s;
    s = {1'b0, a} + b;
    if (s > SCORE_CAP) return SCORE_CAP[15:0];
    else               return s[15:0];
  endfunction

  // Game FSM with registered outputs; esc behaves like reset but keeps high score.
  always_ff @(posedge Clk) begin
    if (!Reset_n || w_esc) begin
      r_state      <= ST_IDLE;
      r_core_reset <= 1'b0;
      r_freeze     <= 1'b1;
      r_lives      <= 2'(LIVES);
      r_level      <= 4'd1;
      r_timer      <= 6'(ROUND_SECONDS);
      r_score      <= '0;
      r_fcnt       <= '0;
    end else begin
      r_core_reset <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (w_start) begin
            r_state      <= ST_PLAY;
            r_core_reset <= 1'b1;
            r_freeze     <= 1'b0;
            r_lives      <= 2'(LIVES);
            r_level      <= 4'd1;
            r_timer      <= 6'(ROUND_SECONDS);
            r_score      <= '0;
            r_fcnt       <= '0;
          end
        end
        ST_PLAY: begin
          // hit > home > timeout > hop; a timer already at 0 still lets home win
          // (with zero bonus), and any exit from PLAY suppresses the decrement.
          if (frog_hit || (!frog_home && w_timeout)) begin
            r_lives  <= r_lives - 2'd1;
            r_state  <= (r_lives == 2'd1) ? ST_OVER : ST_DYING;
            r_freeze <= 1'b1;
            r_fcnt   <= '0;
          end else if (frog_home) begin
            r_score  <= f_sat_add(r_score, 17'(PTS_HOME) + {11'd0, r_timer});
            r_state  <= ST_CLEAR;
            r_freeze <= 1'b1;
            r_fcnt   <= '0;
          end else begin
            if (frog_hop) begin
              r_score <= f_sat_add(r_score, 17'(PTS_STEP));
            end
            if (frame_tick) begin
              if (w_sec_wrap) begin
                r_fcnt  <= '0;
                r_timer <= r_timer - 6'd1;
              end else begin
                r_fcnt  <= r_fcnt + CW'(1);
              end
            end
          end
        end
        ST_DYING: begin
          if (frame_tick) begin
            if (w_death_done) begin
              r_state      <= ST_PLAY;
              r_core_reset <= 1'b1;
              r_freeze     <= 1'b0;
              r_timer      <= 6'(ROUND_SECONDS);
              r_fcnt       <= '0;
            end else begin
              r_fcnt <= r_fcnt + CW'(1);
            end
          end
        end
        ST_CLEAR: begin
          if (frame_tick) begin
            r_state      <= ST_PLAY;
            r_core_reset <= 1'b1;
            r_freeze     <= 1'b0;
            r_timer      <= 6'(ROUND_SECONDS);
            r_fcnt       <= '0;
            if (r_level != 4'd15) r_level <= r_level + 4'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_freeze <= 1'b1;
        end
      endcase
    end
  end

  assign state      = r_state;
  assign core_reset = r_core_reset;
  assign freeze     = r_freeze;
  assign lives      = r_lives;
  assign level      = r_level;
  assign timer      = r_timer;
  assign score      = r_score;

`ifdef GAME_SEQ_HIGHSCORE_EN
  logic [15:0] r_high_score;
  logic        r_hs_mode;
  logic [15:0] r_score_disp;

  // High score tracks the best score; only a hard reset clears it.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_high_score <= '0;
    end else if (r_score > r_high_score) begin
      r_high_score <= r_score;
    end
  end

  // Display select: holding the H key shows the high score.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_hs_mode    <= 1'b0;
      r_score_disp <= '0;
    end else begin
      r_hs_mode    <= (keycode == KEY_HS);
      r_score_disp <= (keycode == KEY_HS) ? r_high_score : r_score;
    end
  end

  assign high_score = r_high_score;
  assign hs_mode    = r_hs_mode;
  assign score_disp = r_score_disp;
`else
  assign high_score = '0;
  assign hs_mode    = 1'b0;
  assign score_disp = r_score;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: table-driven vectors plus hand-written multi-cycle
// sequences; expectations are queued with the cycle they are due and
// compared by a monitor on the falling clock edge.
module tb_game_sequencer;

`ifdef GAME_SEQ_HIGHSCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [7:0]  keycode;
  logic        frame_tick, frog_hop, frog_hit, frog_home;
  logic        core_reset, freeze, hs_mode;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [3:0]  level;
  logic [5:0]  timer;
  logic [15:0] score, high_score, score_disp;

  game_sequencer #(
    .LIVES(3), .FRAMES_PER_SEC(60), .ROUND_SECONDS(30),
    .DEATH_FRAMES(60), .PTS_STEP(10), .PTS_HOME(50)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_tick(frame_tick),
    .frog_hop(frog_hop), .frog_hit(frog_hit), .frog_home(frog_home),
    .core_reset(core_reset), .freeze(freeze), .state(state), .lives(lives),
    .level(level), .timer(timer), .score(score), .high_score(high_score),
    .score_disp(score_disp), .hs_mode(hs_mode)
  );

  always #5 Clk = ~Clk;

  typedef enum int {F_ST, F_SC, F_LV, F_LVL, F_TM, F_CR, F_FZ, F_HS, F_HM, F_DISP} fld_t;
  typedef struct { int due; fld_t fld; int exp; string name; } sb_t;
  typedef struct {
    logic [7:0] key; logic hop; logic hit; logic home; logic tick;
    int st; int sc; int lv; int lvl; int tm; int cr; int fz;
  } vec_t;

  sb_t sb[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int actual(fld_t f);
    case (f)
      F_ST:    return int'(state);
      F_SC:    return int'(score);
      F_LV:    return int'(lives);
      F_LVL:   return int'(level);
      F_TM:    return int'(timer);
      F_CR:    return int'(core_reset);
      F_FZ:    return int'(freeze);
      F_HS:    return int'(high_score);
      F_HM:    return int'(hs_mode);
      default: return int'(score_disp);
    endcase
  endfunction

  // Monitor: compare every expectation that has come due.
  always @(negedge Clk) begin
    sb_t e;
    int  a;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      a = actual(e.fld);
      checks++;
      if (a != e.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.exp, cyc);
      end
    end
  end

  task automatic expect_f(input fld_t f, input int e, input string n);
    sb.push_back('{cyc + 1, f, e, n});
  endtask

  task automatic apply(input logic [7:0] k, input logic hp, input logic ht,
                       input logic hm, input logic tk);
    keycode = k; frog_hop = hp; frog_hit = ht; frog_home = hm; frame_tick = tk;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b1); step();
      apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b0); step();
    end
  endtask

  task automatic run_vec(input vec_t v, input string p);
    apply(v.key, v.hop, v.hit, v.home, v.tick);
    expect_f(F_ST,  v.st,  {p, "_state"});
    expect_f(F_SC,  v.sc,  {p, "_score"});
    expect_f(F_LV,  v.lv,  {p, "_lives"});
    expect_f(F_LVL, v.lvl, {p, "_level"});
    expect_f(F_TM,  v.tm,  {p, "_timer"});
    expect_f(F_CR,  v.cr,  {p, "_core_reset"});
    expect_f(F_FZ,  v.fz,  {p, "_freeze"});
    step();
  endtask

  vec_t t1[8];
  vec_t t2[4];

  initial begin
    //        key    hop  hit  home tick  st sc  lv lvl tm cr fz
    t1[0] = '{8'h00, 1'b0,1'b0,1'b0,1'b0, 0, 0,  3, 1, 30, 0, 1};
    t1[1] = '{8'h00, 1'b1,1'b1,1'b0,1'b0, 0, 0,  3, 1, 30, 0, 1};
    t1[2] = '{8'h2C, 1'b0,1'b0,1'b0,1'b0, 1, 0,  3, 1, 30, 1, 0};
    t1[3] = '{8'h00, 1'b0,1'b0,1'b0,1'b0, 1, 0,  3, 1, 30, 0, 0};
    t1[4] = '{8'h00, 1'b1,1'b0,1'b0,1'b0, 1, 10, 3, 1, 30, 0, 0};
    t1[5] = '{8'h00, 1'b1,1'b0,1'b0,1'b0, 1, 20, 3, 1, 30, 0, 0};
    t1[6] = '{8'h00, 1'b1,1'b0,1'b0,1'b0, 1, 30, 3, 1, 30, 0, 0};
    t1[7] = '{8'h00, 1'b0,1'b0,1'b0,1'b0, 1, 30, 3, 1, 30, 0, 0};
    t2[0] = '{8'h00, 1'b1,1'b1,1'b0,1'b0, 2, 105,2, 2, 30, 0, 1};
    t2[1] = '{8'h00, 1'b1,1'b0,1'b0,1'b0, 2, 105,2, 2, 30, 0, 1};
    t2[2] = '{8'h00, 1'b0,1'b0,1'b1,1'b0, 2, 105,2, 2, 30, 0, 1};
    t2[3] = '{8'h2C, 1'b0,1'b0,1'b0,1'b0, 2, 105,2, 2, 30, 0, 1};

    Reset_n = 1'b0;
    apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    // Reset values
    expect_f(F_ST, 0, "rst_state");   expect_f(F_SC, 0, "rst_score");
    expect_f(F_LV, 3, "rst_lives");   expect_f(F_LVL, 1, "rst_level");
    expect_f(F_TM, 30, "rst_timer");  expect_f(F_CR, 0, "rst_core_reset");
    expect_f(F_FZ, 1, "rst_freeze");  expect_f(F_HS, 0, "rst_high");
    expect_f(F_HM, 0, "rst_hs_mode");
    step();
    Reset_n = 1'b1;

    // Start, ignored events while frozen, three hops
    for (int i = 0; i < 8; i++) run_vec(t1[i], $sformatf("t1_%0d", i));

    // Timer to 25, then home: 30 + 50 + 25
    ticks(300);
    apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_f(F_TM, 25, "timer25"); step();
    apply(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_f(F_SC, 105, "home_score"); expect_f(F_ST, 3, "home_state");
    expect_f(F_FZ, 1, "home_freeze");  step();
    apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_f(F_ST, 3, "clear_wait"); step();
    apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_f(F_ST, 1, "clear_state"); expect_f(F_LVL, 2, "clear_level");
    expect_f(F_TM, 30, "clear_timer"); expect_f(F_CR, 1, "clear_core_reset");
    step();

    // Hit beats hop; frozen events ignored while dying
    for (int i = 0; i < 4; i++) run_vec(t2[i], $sformatf("t2_%0d", i));
    ticks(59);
    apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_f(F_ST, 2, "dying59_state"); step();
    apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_f(F_ST, 1, "respawn_state"); expect_f(F_CR, 1, "respawn_core_reset");
    expect_f(F_TM, 30, "respawn_timer"); expect_f(F_FZ, 0, "respawn_freeze");
    step();
    apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_f(F_CR, 0, "respawn_cr_drop"); step();

    // Esc back to IDLE, then restart
    apply(8'h29, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_f(F_ST, 0, "esc_state"); expect_f(F_SC, 0, "esc_score");
    expect_f(F_LV, 3, "esc_lives"); expect_f(F_LVL, 1, "esc_level");
    expect_f(F_FZ, 1, "esc_freeze"); expect_f(F_CR, 0, "esc_core_reset");
    step();
    apply(8'h2C, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_f(F_ST, 1, "restart_state"); expect_f(F_CR, 1, "restart_core_reset");
    step();

    // Timer at 0 with home: home wins, bonus 0
    ticks(1799);
    apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_f(F_TM, 0, "t0_timer"); expect_f(F_ST, 1, "t0_state"); step();
    apply(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_f(F_ST, 3, "t0home_state"); expect_f(F_SC, 50, "t0home_score");
    expect_f(F_LV, 3, "t0home_lives"); step();
    apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_f(F_ST, 1, "t0clear_state"); expect_f(F_TM, 30, "t0clear_timer");
    step();

    // Three timeouts end the game
    for (int r = 1; r <= 3; r++) begin
      ticks(1799);
      apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_f(F_TM, 0, $sformatf("to%0d_timer", r));
      expect_f(F_LV, 4 - r, $sformatf("to%0d_lives_before", r));
      step();
      apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_f(F_LV, 3 - r, $sformatf("to%0d_lives", r));
      expect_f(F_ST, (r < 3) ? 2 : 4, $sformatf("to%0d_state", r));
      expect_f(F_FZ, 1, $sformatf("to%0d_freeze", r));
      step();
      if (r < 3) begin
        ticks(59);
        apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_f(F_ST, 1, $sformatf("to%0d_respawn", r));
        expect_f(F_TM, 30, $sformatf("to%0d_reload", r));
        step();
      end
    end
    apply(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_f(F_ST, 4, "over_state"); expect_f(F_SC, 50, "over_hop_ignored");
    step();

    // Score saturation
    apply(8'h2C, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_f(F_ST, 1, "cap_start"); expect_f(F_SC, 0, "cap_score0");
    expect_f(F_LV, 3, "cap_lives"); expect_f(F_CR, 1, "cap_core_reset");
    step();
    for (int i = 0; i < 992; i++) begin
      apply(8'h00, 1'b1, 1'b0, 1'b0, 1'b0); step();
    end
    apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_f(F_SC, 9920, "cap_9920"); step();
    ticks(300);
    apply(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_f(F_SC, 9995, "cap_9995"); expect_f(F_ST, 3, "cap_clear"); step();
    apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_f(F_ST, 1, "cap_play"); expect_f(F_LVL, 2, "cap_level"); step();
    apply(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_f(F_SC, 9999, "cap_sat1"); step();
    apply(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_f(F_SC, 9999, "cap_sat2"); step();

    // High-score display
    apply(8'h0B, 1'b0, 1'b0, 1'b0, 1'b0); step();
    apply(8'h0B, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_f(F_HM, HS_EN ? 1 : 0, "hs_mode_on");
    expect_f(F_HS, HS_EN ? 9999 : 0, "hs_value");
    expect_f(F_DISP, 9999, "hs_disp");
    step();
    apply(8'h29, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_f(F_ST, 0, "esc2_state"); expect_f(F_SC, 0, "esc2_score");
    expect_f(F_HS, HS_EN ? 9999 : 0, "esc2_high_kept");
    step();
    apply(8'h0B, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_f(F_DISP, HS_EN ? 9999 : 0, "esc2_disp");
    expect_f(F_HM, HS_EN ? 1 : 0, "esc2_hs_mode");
    step();

    // Hard reset clears high score
    Reset_n = 1'b0;
    apply(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_f(F_HS, 0, "rst2_high"); expect_f(F_ST, 0, "rst2_state");
    expect_f(F_HM, 0, "rst2_hs_mode");
    step();
    Reset_n = 1'b1;
    step();
    step();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
